// File: rtl/linked_list_walker.sv
// ---------------------------------------------------------------------------
// linked_list_walker: walks a linked list head-to-tail with Read ops and
// streams every node out on a valid/ready port.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module linked_list_walker #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_NODE   = 8,
  parameter  int TIMEOUT    = 16,
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [1:0]            ll_op,
  output logic                  ll_op_start,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  input  logic [DATA_WIDTH-1:0] ll_data_out,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic                  ll_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err,
  output logic [ADDR_WIDTH-1:0] node_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = ADDR_WIDTH'(MAX_NODE);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_FAULT   = 3'd1;
  localparam logic [2:0] ERR_LOOP    = 3'd2;
  localparam logic [2:0] ERR_BADPTR  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ABORT   = 3'd5;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ll_addr_q, ll_addr_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] hop_q, hop_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] node_count_q, node_count_d;
  logic [2:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  ll_op_start_q, out_valid_q, busy_q, done_q;

  logic [ADDR_WIDTH-1:0] hop_inc;
  assign hop_inc = hop_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ll_addr_d    = ll_addr_q;
    next_d       = next_q;
    hop_d        = hop_q;
    tmo_d        = tmo_q;
    node_count_d = node_count_q;
    err_d        = err_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d        = ERR_OK;
          node_count_d = '0;
          if (ll_empty || (ll_head == ADDR_NULL)) begin
            state_d = S_FIN;
          end else begin
            ll_addr_d = ll_head;
            hop_d     = '0;
            tmo_d     = '0;
            state_d   = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (ll_op_done) begin
          next_d = ll_next_node_addr;
          if (ll_fault) begin
            err_d   = ERR_FAULT;
            state_d = S_FIN;
          end else if (abort) begin
            err_d   = ERR_ABORT;
            state_d = S_FIN;
          end else begin
            hop_d      = hop_inc;
            out_data_d = ll_data_out;
            out_addr_d = ll_addr_q;
            // Last-beat flag is known up front so the stream sink sees it with the beat.
            out_last_d = (ll_next_node_addr == ADDR_NULL) ||
                         (ll_next_node_addr >= MAX_ADDR) ||
                         (hop_inc == MAX_ADDR);
            state_d    = S_EMIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          node_count_d = node_count_q + 1'b1;
          out_last_d   = 1'b0;
          state_d      = S_FIN;
          if (next_q == ADDR_NULL) begin
            err_d = ERR_OK;
          end else if (next_q >= MAX_ADDR) begin
            err_d = ERR_BADPTR;
          end else if (hop_q == MAX_ADDR) begin
            err_d = ERR_LOOP;
          end else if (abort) begin
            err_d = ERR_ABORT;
          end else begin
            ll_addr_d = next_q;
            tmo_d     = '0;
            state_d   = S_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ll_addr_q     <= ADDR_NULL;
      next_q        <= '0;
      hop_q         <= '0;
      tmo_q         <= '0;
      node_count_q  <= '0;
      err_q         <= ERR_OK;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
      ll_op_start_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ll_addr_q     <= ll_addr_d;
      next_q        <= next_d;
      hop_q         <= hop_d;
      tmo_q         <= tmo_d;
      node_count_q  <= node_count_d;
      err_q         <= err_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
      ll_op_start_q <= (state_d == S_REQ);
      out_valid_q   <= (state_d == S_EMIT);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_FIN);
    end
  end

  assign ll_op       = 2'd0;
  assign ll_op_start = ll_op_start_q;
  assign ll_addr     = ll_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign node_count  = node_count_q;

endmodule

`default_nettype wire

// File: doc/linked_list_walker.md
Name: linked_list_walker

Overview:
Read-side traversal engine for the singly linked list block. It acts as the initiator on the list's op/op_start/op_done command port. On a single start pulse it walks the list from head to tail, issuing one Read op per node and following each returned next-node address. It emits every node as a beat on a valid/ready output stream, then reports node count and completion status. Typical users are a debug dump path and a DMA-style drain of list contents.

Parameters:
DATA_WIDTH, 8, node data width; must match the list instance.
MAX_NODE, 8, list capacity; must match the list instance. ADDR_WIDTH = $clog2(MAX_NODE+1). ADDR_NULL = MAX_NODE+1.
TIMEOUT, 16, maximum cycles to wait for ll_op_done per request (≥2).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  begin traversal; sampled only in IDLE
abort  input  1  request early stop; level-sampled
ll_op  output  2  list op code; always 2'd0 (Read)
ll_op_start  output  1  list request strobe
ll_addr  output  ADDR_WIDTH  node address being read
ll_data_out  input  DATA_WIDTH  list read data
ll_next_node_addr  input  ADDR_WIDTH  list next pointer of the read node
ll_op_done  input  1  list completion
ll_fault  input  1  list fault
ll_head  input  ADDR_WIDTH  list head address
ll_empty  input  1  list empty flag
out_valid  output  1  stream beat valid
out_ready  input  1  stream beat accept
out_data  output  DATA_WIDTH  node data
out_addr  output  ADDR_WIDTH  node address
out_last  output  1  final beat of this traversal
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse
err  output  3  0 OK, 1 FAULT, 2 LOOP, 3 BADPTR, 4 TIMEOUT, 5 ABORT
node_count  output  ADDR_WIDTH  beats accepted in the last/current traversal

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except ll_addr=ADDR_NULL. Internal hop/timeout counters cleared. A reset mid-traversal simply abandons the traversal. The list must be reset alongside.
- All outputs are registered. ll_op is tied to 0.
- States: IDLE, REQ, EMIT, FIN.
- IDLE: on start:
  - If ll_empty=1 or ll_head==ADDR_NULL: go FIN with err=OK, node_count=0, no beats emitted.
  - Otherwise: ll_addr←ll_head, node_count←0, hop←0, err←0, go REQ.
- REQ: ll_op_start=1. ll_addr is held stable until ll_op_done is sampled high.
  - On ll_op_done=1: ll_op_start drops on the next edge. Capture ll_data_out, ll_next_node_addr and ll_fault. Responder latency is ≥1 cycle.
  - If ll_fault=1: err=FAULT, go FIN with no beat.
  - Else if abort=1 is sampled in the same cycle: err=ABORT, go FIN.
  - Otherwise: hop+1, go EMIT.
  - Timeout counter counts REQ cycles. After TIMEOUT cycles without ll_op_done: drop ll_op_start, err=TIMEOUT, go FIN.
- EMIT: out_valid=1 with out_data, out_addr=ll_addr.
  - out_last=1 iff next==ADDR_NULL, or next≥MAX_NODE, or hop==MAX_NODE.
  - Beat fields are stable while out_valid=1 and out_ready=0. abort never drops a pending beat.
  - On out_valid&out_ready: node_count+1, then take the first matching case:
    - next==ADDR_NULL → FIN, err=OK.
    - next≥MAX_NODE → FIN, err=BADPTR.
    - hop==MAX_NODE → FIN, err=LOOP (cycle guard).
    - abort=1 → FIN, err=ABORT.
    - else ll_addr←next, go REQ.
- FIN: done=1 for exactly one cycle, then IDLE. busy=1 in REQ/EMIT/FIN. err and node_count hold until the next accepted start.
- start while busy is ignored. abort in IDLE is ignored.
- Throughput: a minimum of 3 cycles per node (REQ≥2, EMIT≥1) with zero backpressure.

Test Plan:
- Build list 0→1→2 with data 0xA1,0xB2,0xC3 via the real list block; pulse start, out_ready=1 → 3 beats (addr 0,1,2; data A1,B2,C3), out_last on 3rd beat only, done pulse, err=0, node_count=3.
- Empty list (after reset) → start gives done 1 cycle after start, no out_valid, node_count=0, err=0.
- Same 3-node list with out_ready toggling 1-of-3 cycles → identical beat sequence, beat fields stable while stalled, no duplicated or dropped beats.
- Stub responder returns ll_fault=1 on the 2nd read → 1 beat emitted, then done, err=1, node_count=1.
- Stub responder returns next=0 forever with MAX_NODE=8 → 8 beats, last has out_last=1, err=2. Stub returns next=12 → err=3 after that beat.
- Stub never asserts ll_op_done → ll_op_start high for exactly 16 cycles, then done with err=4. Assert rst low mid-EMIT → all outputs return to reset values immediately.
